// File: rtl/nav_position_integrator.sv
// Per-axis signed position integrator with mode-selected step speed, selectable
// clamp/wrap overflow, and a valid/ready command port for clear, home, load and warp.
module nav_position_integrator #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned AXES          = 3,
  parameter int unsigned ATTACK_SPEED  = 4,
  parameter int unsigned DEFENSE_SPEED = 2,
  parameter int unsigned STEALTH_SPEED = 1,
  parameter bit          SATURATE      = 1'b1,
  parameter int unsigned WARP_CHARGE   = 8,
  parameter int unsigned WARP_COOLDOWN = 4,
  localparam int unsigned AXW          = (AXES > 1) ? $clog2(AXES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mode_sel,
  input  logic                  step_en,
  input  logic [AXES-1:0]       axis_en,
  input  logic [AXES-1:0]       dir,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [AXW-1:0]        cmd_axis,
  input  logic [WIDTH-1:0]      cmd_data,
  output logic [AXES*WIDTH-1:0] pos_flat,
  output logic [AXES-1:0]       ovf_flag,
  output logic                  cmd_err,
  output logic                  warping
);

  localparam int unsigned CntMax = (WARP_CHARGE > WARP_COOLDOWN) ? WARP_CHARGE : WARP_COOLDOWN;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StCruise, StCharge, StJump, StCooldown} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              warping_q;
  logic [WIDTH-1:0]  pos_q [AXES];
  logic [WIDTH-1:0]  pos_d [AXES];
  logic [AXES-1:0]   ovf_q, ovf_d, ovf_set;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  off_q, off_d;
  logic [AXES-1:0]   mask_q, mask_d;

  logic              cmd_acc, acc_clr, acc_home, acc_warp, acc_load;
  logic              bad_mode, bad_axis;
  logic [WIDTH-1:0]  speed;

  // Bit WIDTH of the result is the overflow indication.
  function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] res;
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf = sum[WIDTH] ^ sum[WIDTH-1];
    if (ovf && SATURATE) begin
      res = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = sum[WIDTH-1:0];
    end
    return {ovf, res};
  endfunction

  always_comb begin
    speed    = '0;
    bad_mode = 1'b0;
    case (mode_sel)
      4'b0001: speed = '0;
      4'b0010: speed = WIDTH'(ATTACK_SPEED);
      4'b0100: speed = WIDTH'(DEFENSE_SPEED);
      4'b1000: speed = WIDTH'(STEALTH_SPEED);
      default: bad_mode = 1'b1;
    endcase
  end

  assign cmd_acc  = cmd_valid && cmd_ready;
  assign acc_clr  = cmd_acc && (cmd_op == 2'b00);
  assign acc_home = cmd_acc && (cmd_op == 2'b01);
  assign acc_warp = cmd_acc && (cmd_op == 2'b10);
  assign acc_load = cmd_acc && (cmd_op == 2'b11);
  assign bad_axis = 32'(cmd_axis) >= AXES;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StCruise;
      cnt_q     <= '0;
      warping_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      warping_q <= (state_d != StCruise);
    end
  end

  // FSM: next state; the counter loads N-1 on entry and leaves the state at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StCruise: begin
        if (acc_warp) begin
          state_d = StCharge;
          cnt_d   = CntW'(WARP_CHARGE - 1);
        end
      end
      StCharge: begin
        if (cnt_q == '0) state_d = StJump;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StJump: begin
        state_d = StCooldown;
        cnt_d   = CntW'(WARP_COOLDOWN - 1);
      end
      StCooldown: begin
        if (cnt_q == '0) state_d = StCruise;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StCruise;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state_q == StCruise);
    warping   = warping_q;
  end

  // Position datapath
  always_comb begin
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] delta;
    r       = '0;
    delta   = '0;
    ovf_set = '0;
    off_d   = off_q;
    mask_d  = mask_q;
    for (int i = 0; i < AXES; i++) begin
      pos_d[i] = pos_q[i];
      if (state_q == StCruise) begin
        if (step_en && axis_en[i]) begin
          delta      = dir[i] ? (WIDTH'(0) - speed) : speed;
          r          = sat_add(pos_q[i], delta);
          pos_d[i]   = r[WIDTH-1:0];
          ovf_set[i] = r[WIDTH];
        end
        if (acc_home) begin
          pos_d[i]   = '0;
          ovf_set[i] = 1'b0;
        end else if (acc_load && !bad_axis && (cmd_axis == AXW'(i))) begin
          pos_d[i]   = cmd_data;
          ovf_set[i] = 1'b0;
        end
      end else if (state_q == StJump && mask_q[i]) begin
        r          = sat_add(pos_q[i], off_q);
        pos_d[i]   = r[WIDTH-1:0];
        ovf_set[i] = r[WIDTH];
      end
    end
    if (acc_warp) begin
      off_d  = cmd_data;
      mask_d = axis_en;
    end
    // A same-cycle set beats the clear.
    ovf_d = (acc_clr ? '0 : ovf_q) | ovf_set;
    err_d = (acc_clr ? 1'b0 : err_q) | bad_mode | (acc_load && bad_axis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < AXES; i++) pos_q[i] <= '0;
      ovf_q  <= '0;
      err_q  <= 1'b0;
      off_q  <= '0;
      mask_q <= '0;
    end else begin
      for (int i = 0; i < AXES; i++) pos_q[i] <= pos_d[i];
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      off_q  <= off_d;
      mask_q <= mask_d;
    end
  end

  always_comb begin
    for (int i = 0; i < AXES; i++) pos_flat[i*WIDTH +: WIDTH] = pos_q[i];
  end

  assign ovf_flag = ovf_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_nav_position_integrator.sv
// Directed bench: one clamping and one wrapping integrator share the same stimulus.
module tb_nav_position_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mode_sel;
  logic        step_en;
  logic [2:0]  axis_en, dir;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_axis;
  logic [15:0] cmd_data;

  logic [47:0] pos_s, pos_w;
  logic [2:0]  ovf_s, ovf_w;
  logic        err_s, err_w, warp_s, warp_w, ready_s, ready_w;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt, guard;

  always #5 clk = ~clk;

  nav_position_integrator #(.SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .step_en(step_en), .axis_en(axis_en),
    .dir(dir), .cmd_valid(cmd_valid), .cmd_ready(ready_s), .cmd_op(cmd_op),
    .cmd_axis(cmd_axis), .cmd_data(cmd_data), .pos_flat(pos_s), .ovf_flag(ovf_s),
    .cmd_err(err_s), .warping(warp_s)
  );

  nav_position_integrator #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .step_en(step_en), .axis_en(axis_en),
    .dir(dir), .cmd_valid(cmd_valid), .cmd_ready(ready_w), .cmd_op(cmd_op),
    .cmd_axis(cmd_axis), .cmd_data(cmd_data), .pos_flat(pos_w), .ovf_flag(ovf_w),
    .cmd_err(err_w), .warping(warp_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] ax, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_axis  = ax;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode_sel = 4'b0001; step_en = 1'b0; axis_en = 3'b000; dir = 3'b000;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_axis = 2'd0; cmd_data = 16'd0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_pos", 64'(pos_s), 64'd0);
    chk("reset_ovf", 64'(ovf_s), 64'd0);
    chk("reset_err", 64'(err_s), 64'd0);
    chk("reset_warping", 64'(warp_s), 64'd0);
    chk("reset_ready", 64'(ready_s), 64'd1);

    // Attack, five steps, axis 1 heading negative.
    mode_sel = 4'b0010; axis_en = 3'b111; dir = 3'b010; step_en = 1'b1;
    repeat (5) tick();
    step_en = 1'b0;
    chk("attack_5_pos", 64'(pos_s), 64'({16'd20, 16'hFFEC, 16'd20}));
    chk("attack_5_ovf", 64'(ovf_s), 64'd0);

    // Load 32760 into axis 0 then step at attack speed toward the positive limit.
    cmd(2'b11, 2'd0, 16'd32760);
    chk("load_axis0", 64'(pos_s), 64'({16'd20, 16'hFFEC, 16'd32760}));
    axis_en = 3'b001; dir = 3'b000; step_en = 1'b1;
    tick();
    chk("sat_step1", 64'(pos_s[15:0]), 64'd32764);
    tick();
    chk("sat_step2", 64'(pos_s[15:0]), 64'd32767);
    chk("wrap_step2", 64'(pos_w[15:0]), 64'h8000);
    tick();
    step_en = 1'b0;
    chk("sat_step3", 64'(pos_s[15:0]), 64'd32767);
    chk("wrap_step3", 64'(pos_w[15:0]), 64'h8004);
    chk("sat_ovf", 64'(ovf_s), 64'b001);
    chk("wrap_ovf", 64'(ovf_w), 64'b001);
    cmd(2'b00, 2'd0, 16'd0);
    chk("clear_ovf", 64'(ovf_s), 64'd0);
    chk("clear_err", 64'(err_s), 64'd0);

    // Defense step from 32766 crosses the limit.
    cmd(2'b11, 2'd0, 16'd32766);
    mode_sel = 4'b0100; step_en = 1'b1;
    tick();
    step_en = 1'b0;
    chk("wrap_defense", 64'(pos_w[15:0]), 64'h8000);
    chk("wrap_defense_ovf", 64'(ovf_w), 64'b001);
    chk("sat_defense", 64'(pos_s[15:0]), 64'd32767);
    cmd(2'b00, 2'd0, 16'd0);

    // Home overrides a concurrent step on every axis.
    axis_en = 3'b111; step_en = 1'b1;
    cmd(2'b01, 2'd0, 16'd0);
    step_en = 1'b0;
    chk("home_pos", 64'(pos_s), 64'd0);
    chk("home_pos_wrap", 64'(pos_w), 64'd0);

    // Warp offset 1000 on axes 0 and 2, with step_en toggled on during the warp.
    axis_en = 3'b101;
    cmd(2'b10, 2'd0, 16'd1000);
    chk("warp_warping", 64'(warp_s), 64'd1);
    axis_en = 3'b111; step_en = 1'b1;
    cnt = 0; guard = 0;
    while (ready_s === 1'b0 && guard < 40) begin
      cnt++; guard++;
      tick();
    end
    step_en = 1'b0;
    chk("warp_busy_cycles", 64'(cnt), 64'd13);
    chk("warp_pos", 64'(pos_s), 64'({16'd1000, 16'd0, 16'd1000}));
    chk("warp_done_warping", 64'(warp_s), 64'd0);

    // Reset during the third charge cycle aborts the warp.
    cmd(2'b10, 2'd0, 16'd5);
    tick(); tick();
    chk("charge_ready_low", 64'(ready_s), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_pos", 64'(pos_s), 64'd0);
    chk("abort_warping", 64'(warp_s), 64'd0);
    chk("abort_ready", 64'(ready_s), 64'd1);

    // Illegal mode: no motion, error raised.
    cmd_data = 16'd0;
    mode_sel = 4'b0110; axis_en = 3'b111; step_en = 1'b1;
    tick();
    step_en = 1'b0; mode_sel = 4'b0001;
    chk("bad_mode_pos", 64'(pos_s), 64'd0);
    chk("bad_mode_err", 64'(err_s), 64'd1);
    cmd(2'b00, 2'd0, 16'd0);
    chk("err_cleared", 64'(err_s), 64'd0);

    // Load to a nonexistent axis is consumed but flagged.
    chk("bad_axis_ready", 64'(ready_s), 64'd1);
    cmd(2'b11, 2'd3, 16'd77);
    chk("bad_axis_pos", 64'(pos_s), 64'd0);
    chk("bad_axis_err", 64'(err_s), 64'd1);
    chk("bad_axis_ready_after", 64'(ready_s), 64'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
